// File: rtl/mac_tap_sequencer_if.sv
// -----------------------------------------------------------------------------
// mac_tap_sequencer_if
// Signal bundle between the FIR tap sequencer and its environment.
//   s_*        : input sample stream (sequencer is the slave)
//   k_wr_*     : coefficient write port
//   acc_clr, enable, i_TDATA, k_TDATA, acc_TDATA : accumulator link
//   m_*        : result stream (sequencer is the master)
//   busy       : sequencer activity flag
// Modports: slave  = sequencer side, master = environment side.
// Optional: `define MAC_TLAST_EN adds s_TLAST to the input stream.
// -----------------------------------------------------------------------------
interface mac_tap_sequencer_if #(
  parameter int N_TAPS = 8
) ();
  localparam int AW = $clog2(N_TAPS);

  logic          s_TVALID;
  logic          s_TREADY;
  logic [15:0]   s_TDATA;
`ifdef MAC_TLAST_EN
  logic          s_TLAST;
`endif
  logic          k_wr_en;
  logic [AW-1:0] k_wr_addr;
  logic [15:0]   k_wr_data;
  logic          acc_clr;
  logic          enable;
  logic [15:0]   i_TDATA;
  logic [15:0]   k_TDATA;
  logic [31:0]   acc_TDATA;
  logic          m_TVALID;
  logic          m_TREADY;
  logic [31:0]   m_TDATA;
  logic          busy;

  modport slave (
`ifdef MAC_TLAST_EN
    input  s_TLAST,
`endif
    input  s_TVALID, s_TDATA, k_wr_en, k_wr_addr, k_wr_data, acc_TDATA, m_TREADY,
    output s_TREADY, acc_clr, enable, i_TDATA, k_TDATA, m_TVALID, m_TDATA, busy
  );

  modport master (
`ifdef MAC_TLAST_EN
    output s_TLAST,
`endif
    output s_TVALID, s_TDATA, k_wr_en, k_wr_addr, k_wr_data, acc_TDATA, m_TREADY,
    input  s_TREADY, acc_clr, enable, i_TDATA, k_TDATA, m_TVALID, m_TDATA, busy
  );
endinterface

// File: rtl/mac_tap_sequencer.sv
// -----------------------------------------------------------------------------
// mac_tap_sequencer
// FIR/convolution tap sequencer feeding an external multiply-accumulate block.
// Each accepted sample is shifted into a tap delay line; the accumulator is
// then cleared, fed N_TAPS (sample, coefficient) pairs, and its final sum is
// captured and offered on the result stream.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : mac_tap_sequencer_if.slave (sample in, coefficient writes,
//             accumulator link, result out, busy)
// Optional: `define MAC_TLAST_EN -- a sample accepted with s_TLAST=1 zeroes the
// delay line once its result has been handed off (coefficients are kept).
// -----------------------------------------------------------------------------
module mac_tap_sequencer #(
  parameter int N_TAPS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mac_tap_sequencer_if.slave    bus
);
  localparam int AW = $clog2(N_TAPS);
  localparam logic [AW-1:0] IDX_LAST = AW'(N_TAPS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_MAC,
    ST_DRAIN,
    ST_OUT
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [15:0]   line_q [N_TAPS];
  logic [15:0]   line_d [N_TAPS];
  logic [15:0]   coef_q [N_TAPS];
  logic [15:0]   coef_d [N_TAPS];
  logic          rdy_q, rdy_d;
  logic          acc_clr_q, acc_clr_d;
  logic          enable_q, enable_d;
  logic [15:0]   i_data_q, i_data_d;
  logic [15:0]   k_data_q, k_data_d;
  logic [31:0]   m_data_q, m_data_d;
`ifdef MAC_TLAST_EN
  logic          last_q, last_d;
`endif

  logic accept;
  logic coef_we;

  // rdy_q is only ever high in IDLE; it stays low for the first cycle after
  // reset release so no sample is taken while the accumulator is still cleared.
  assign accept  = bus.s_TVALID & rdy_q;
  // Address guard matters for non-power-of-two N_TAPS.
  assign coef_we = bus.k_wr_en && (state_q == ST_IDLE) &&
                   ({{(32-AW){1'b0}}, bus.k_wr_addr} < 32'(N_TAPS));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    line_d   = line_q;
    coef_d   = coef_q;
    m_data_d = m_data_q;
`ifdef MAC_TLAST_EN
    last_d   = last_q;
`endif

    // A write in the accept cycle lands before CLEAR, so MAC sees it.
    if (coef_we) begin
      coef_d[bus.k_wr_addr] = bus.k_wr_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          for (int j = N_TAPS - 1; j > 0; j--) begin
            line_d[j] = line_q[j-1];
          end
          line_d[0] = bus.s_TDATA;
`ifdef MAC_TLAST_EN
          last_d    = bus.s_TLAST;
`endif
          state_d   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        idx_d   = '0;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // The last product was added on the edge entering DRAIN.
        m_data_d = bus.acc_TDATA;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        if (bus.m_TREADY) begin
`ifdef MAC_TLAST_EN
          if (last_q) begin
            for (int j = 0; j < N_TAPS; j++) begin
              line_d[j] = '0;
            end
          end
          last_d = 1'b0;
`endif
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    rdy_d     = (state_d == ST_IDLE);
    acc_clr_d = (state_d == ST_CLEAR);
    enable_d  = (state_d == ST_MAC);
    i_data_d  = enable_d ? line_q[idx_d] : 16'd0;
    k_data_d  = enable_d ? coef_q[idx_d] : 16'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      rdy_q     <= 1'b0;
      acc_clr_q <= 1'b1;
      enable_q  <= 1'b0;
      i_data_q  <= '0;
      k_data_q  <= '0;
      m_data_q  <= '0;
`ifdef MAC_TLAST_EN
      last_q    <= 1'b0;
`endif
      for (int j = 0; j < N_TAPS; j++) begin
        line_q[j] <= '0;
        coef_q[j] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rdy_q     <= rdy_d;
      acc_clr_q <= acc_clr_d;
      enable_q  <= enable_d;
      i_data_q  <= i_data_d;
      k_data_q  <= k_data_d;
      m_data_q  <= m_data_d;
`ifdef MAC_TLAST_EN
      last_q    <= last_d;
`endif
      for (int j = 0; j < N_TAPS; j++) begin
        line_q[j] <= line_d[j];
        coef_q[j] <= coef_d[j];
      end
    end
  end

  assign bus.s_TREADY = rdy_q;
  assign bus.acc_clr  = acc_clr_q;
  assign bus.enable   = enable_q;
  assign bus.i_TDATA  = i_data_q;
  assign bus.k_TDATA  = k_data_q;
  assign bus.m_TVALID = (state_q == ST_OUT);
  assign bus.m_TDATA  = m_data_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mac_tap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_tap_sequencer
// Directed bench: N_TAPS=4, coefficients {1,2,3,4}, behavioural accumulator
// (cleared by acc_clr, unsigned 16x16 products summed with 32-bit wrap).
// Expected results are hand-computed from the delay-line contents.
// -----------------------------------------------------------------------------
module tb_mac_tap_sequencer;
  localparam int N_TAPS = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic [31:0] acc;
  int total = 0;
  int bad   = 0;

  mac_tap_sequencer_if #(.N_TAPS(N_TAPS)) bus ();

  mac_tap_sequencer #(.N_TAPS(N_TAPS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Accumulator: its reset input is tied to acc_clr.
  always_ff @(posedge clk or posedge bus.acc_clr) begin
    if (bus.acc_clr) begin
      acc <= 32'd0;
    end else if (bus.enable) begin
      acc <= acc + (32'(bus.i_TDATA) * 32'(bus.k_TDATA));
    end
  end
  assign bus.acc_TDATA = acc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic wr_coef(input logic [1:0] a, input logic [15:0] d);
    bus.k_wr_en   = 1'b1;
    bus.k_wr_addr = a;
    bus.k_wr_data = d;
    @(negedge clk);
    bus.k_wr_en   = 1'b0;
  endtask

  // Called and returns at a negedge. stall>0 holds m_TREADY low that many
  // cycles in OUT while offering sample nxt; pre_wr writes coef[0]=5 in the
  // accept cycle; mid_wr writes coef[2]=100 during MAC.
  task automatic send(input string tag, input logic [15:0] d, input logic last,
                      input logic [31:0] exp, input int stall, input logic [15:0] nxt,
                      input logic pre_wr, input logic mid_wr);
    int n;
    int cnt;
    int en;
    int viol;
    logic [31:0] held;
    bus.m_TREADY = (stall == 0);
    bus.s_TVALID = 1'b1;
    bus.s_TDATA  = d;
`ifdef MAC_TLAST_EN
    bus.s_TLAST  = last;
`endif
    if (pre_wr) begin
      bus.k_wr_en   = 1'b1;
      bus.k_wr_addr = 2'd0;
      bus.k_wr_data = 16'd5;
    end
    n = 0;
    while (!bus.s_TREADY && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_rdy"}, bus.s_TREADY, 1'b1);
    @(posedge clk);
    #1;
    bus.s_TVALID = 1'b0;
    bus.k_wr_en  = 1'b0;
    cnt = 0;
    en  = 0;
    while (cnt < 40) begin
      @(negedge clk);
      bus.k_wr_en = 1'b0;
      if (bus.m_TVALID) break;
      cnt++;
      if (bus.enable) en++;
      if (cnt == 1) check_val({tag, "_clr"}, bus.acc_clr, 1'b1);
      if (cnt == 2) check_val({tag, "_busy"}, bus.busy, 1'b1);
      if (mid_wr && cnt == 2) begin
        bus.k_wr_en   = 1'b1;
        bus.k_wr_addr = 2'd2;
        bus.k_wr_data = 16'd100;
      end
    end
    check_val({tag, "_lat"}, 32'(cnt), 32'd6);
    check_val({tag, "_en"}, 32'(en), 32'd4);
    check_val({tag, "_res"}, bus.m_TDATA, exp);
    if (stall > 0) begin
      held = bus.m_TDATA;
      viol = 0;
      bus.s_TVALID = 1'b1;
      bus.s_TDATA  = nxt;
      for (int c = 0; c < stall; c++) begin
        @(negedge clk);
        if (bus.s_TREADY || !bus.m_TVALID || bus.m_TDATA !== held) viol++;
      end
      check_val({tag, "_stall"}, 32'(viol), 32'd0);
      bus.m_TREADY = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check_val({tag, "_drop"}, bus.m_TVALID, 1'b0);
    $display("xact %s sample=%0d last=%0d result=%0d lat=%0d en=%0d", tag, d, last,
             held_or(bus.m_TDATA), cnt, en);
  endtask

  function automatic logic [31:0] held_or(input logic [31:0] v);
    return v;
  endfunction

  initial begin
    reset_n       = 1'b0;
    bus.s_TVALID  = 1'b0;
    bus.s_TDATA   = '0;
`ifdef MAC_TLAST_EN
    bus.s_TLAST   = 1'b0;
`endif
    bus.k_wr_en   = 1'b0;
    bus.k_wr_addr = '0;
    bus.k_wr_data = '0;
    bus.m_TREADY  = 1'b1;

    // 1. reset and idle
    repeat (3) @(negedge clk);
    check_val("rst_clr",    bus.acc_clr,  1'b1);
    check_val("rst_rdy",    bus.s_TREADY, 1'b0);
    check_val("rst_en",     bus.enable,   1'b0);
    check_val("rst_i",      bus.i_TDATA,  16'd0);
    check_val("rst_k",      bus.k_TDATA,  16'd0);
    check_val("rst_mvalid", bus.m_TVALID, 1'b0);
    check_val("rst_mdata",  bus.m_TDATA,  32'd0);
    check_val("rst_busy",   bus.busy,     1'b0);
    reset_n = 1'b1;
    #1;
    check_val("rel_clr_hold", bus.acc_clr, 1'b1);
    @(negedge clk);
    check_val("rel_clr", bus.acc_clr,  1'b0);
    check_val("rel_rdy", bus.s_TREADY, 1'b1);
    $display("xact reset released");

    wr_coef(2'd0, 16'd1);
    wr_coef(2'd1, 16'd2);
    wr_coef(2'd2, 16'd3);
    wr_coef(2'd3, 16'd4);

    // 2. back-to-back: line [10], [20,10], [30,20,10]
    send("s10", 16'd10, 1'b0, 32'd10,  0, 16'd0, 1'b0, 1'b0);
    send("s20", 16'd20, 1'b0, 32'd40,  0, 16'd0, 1'b0, 1'b0);
    send("s30", 16'd30, 1'b0, 32'd100, 0, 16'd0, 1'b0, 1'b0);
    // 3. backpressure: [40,30,20,10] -> 200, then 50 -> [50,40,30,20] -> 300
    send("s40", 16'd40, 1'b0, 32'd200, 10, 16'd50, 1'b0, 1'b0);
    send("s50", 16'd50, 1'b0, 32'd300, 0, 16'd0, 1'b0, 1'b0);
    // 4. coef[2]=100 during MAC ignored: [60,50,40,30] -> 60+100+120+120
    send("s60", 16'd60, 1'b0, 32'd400, 0, 16'd0, 1'b0, 1'b1);
    // coef[0]=5 with sample 7: [7,60,50,40] -> 35+120+150+160
    send("s7",  16'd7,  1'b0, 32'd465, 0, 16'd0, 1'b1, 1'b0);

    // 5. reset at MAC idx=2 with line [11,7,60,50], coef [5,2,3,4]
    bus.s_TVALID = 1'b1;
    bus.s_TDATA  = 16'd11;
    @(posedge clk);
    #1;
    bus.s_TVALID = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("mid_i",  bus.i_TDATA, 16'd60);
    check_val("mid_k",  bus.k_TDATA, 16'd3);
    check_val("mid_en", bus.enable,  1'b1);
    reset_n = 1'b0;
    #1;
    check_val("mr_clr",    bus.acc_clr,   1'b1);
    check_val("mr_en",     bus.enable,    1'b0);
    check_val("mr_i",      bus.i_TDATA,   16'd0);
    check_val("mr_k",      bus.k_TDATA,   16'd0);
    check_val("mr_rdy",    bus.s_TREADY,  1'b0);
    check_val("mr_mvalid", bus.m_TVALID,  1'b0);
    check_val("mr_mdata",  bus.m_TDATA,   32'd0);
    check_val("mr_busy",   bus.busy,      1'b0);
    check_val("mr_acc",    bus.acc_TDATA, 32'd0);
    $display("xact reset mid-MAC");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wr_coef(2'd0, 16'd1);
    wr_coef(2'd1, 16'd2);
    wr_coef(2'd2, 16'd3);
    wr_coef(2'd3, 16'd4);
    send("s9", 16'd9, 1'b0, 32'd9, 0, 16'd0, 1'b0, 1'b0);

`ifdef MAC_TLAST_EN
    // 6. frame boundaries: flush [0,9] -> 18, then fresh frames
    send("f0",  16'd0,  1'b1, 32'd18, 0, 16'd0, 1'b0, 1'b0);
    send("f10", 16'd10, 1'b0, 32'd10, 0, 16'd0, 1'b0, 1'b0);
    send("f20", 16'd20, 1'b1, 32'd40, 0, 16'd0, 1'b0, 1'b0);
    send("f30", 16'd30, 1'b0, 32'd30, 0, 16'd0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
